wvb_reader: RTL and testbench
=============================

// Module: wvb_reader
// PURPOSE
//  Downstream consumer of waveform_acquisition's reader interface. Pops one header,
//  drains that event's samples from the waveform buffer and writes the event as
//  16-bit words into the XDOM readout DPRAM. Then holds the DPRAM until the host
//  acknowledges it. One event in flight at a time.
// PARAMETERS
//  P_DATA_WIDTH        22  wvb sample word width
//  P_HDR_WIDTH         80  header word width
//  P_ADR_WIDTH         12  wvb address width (start/stop fields)
//  P_LTC_WIDTH         48  local time counter width
//  P_DPRAM_ADR_WIDTH   10  readout DPRAM word-address width (depth 1024 x 16)
// PORTS
//  clk            in   1                    system clock
//  rst            in   1                    synchronous, active-high reset
//  en             in   1                    readout enable
//  hdr_empty      in   1                    wvb header FIFO empty
//  hdr_data       in   P_HDR_WIDTH          show-ahead header word
//  hdr_rdreq      out  1                    pop header (1-cycle pulse)
//  wvb_data       in   P_DATA_WIDTH         sample word, valid 1 cycle after wvb_rdreq
//  wvb_rdreq      out  1                    read one sample
//  wvb_rddone     out  1                    event drained (1-cycle pulse)
//  dpram_a        out  P_DPRAM_ADR_WIDTH    DPRAM write address
//  dpram_data     out  16                   DPRAM write data
//  dpram_wren     out  1                    DPRAM write enable
//  dpram_len      out  P_DPRAM_ADR_WIDTH+1  words written for the current event
//  dpram_rdy      out  1                    event complete in DPRAM, level
//  dpram_done     in   1                    host ack, 1-cycle pulse
// BEHAVIOUR
//  Header fields:
//   ltc=[79:32]; start=[31:20]; stop=[19:8]; trig_src=[7:6]; cnst_run=[5].
//  Sample fields:
//   eoe=[21] (last sample); tot=[20]; discr=[19:12]; adc=[11:0].
//  n_smp = (stop - start + 1) mod 2^P_ADR_WIDTH, 0 read as 4096.
//  DPRAM format:
//   w0 = {tag, n_smp[11:0]}; tag 4'h9 normal, 4'hA truncated.
//   w1..w3 = ltc[47:32], ltc[31:16], ltc[15:0].
//   w4 = {trig_src, cnst_run, 1'b0, start}.
//   Per sample: {tot, eoe, 2'b0, adc}, then {8'h00, discr}.
//  Reset: all outputs 0; FSM to IDLE. dpram_rdy is cleared even mid-event.
//  FSM states and transitions:
//   IDLE: en && !hdr_empty && !dpram_rdy -> HDR. Otherwise stay.
//   HDR: latch hdr_data into the header register; pulse hdr_rdreq -> HDR_WR.
//   HDR_WR: write w1..w4 at a=1..4 (4 cycles) -> SMP. w0 is written last, in DONE.
//   SMP: 2-cycle loop per sample.
//    Phase 0 asserts wvb_rdreq.
//    Phase 1 writes word A. The next phase 0 writes word B and overlaps the next rdreq.
//    Per-sample rate: 1 sample per 2 clk.
//    Loop exit: on eoe=1, write the final word B -> DONE.
//  Write address: starts at 5 and increments once per write.
//  DONE: write w0 at a=0; pulse wvb_rddone; set dpram_len = 5 + 2*n_written;
//   set dpram_rdy=1 -> WAIT.
//  WAIT: on dpram_done, clear dpram_rdy -> IDLE.
//  Truncation: when the write address would exceed 2^P_DPRAM_ADR_WIDTH-1,
//   - dpram_wren is suppressed;
//   - samples are still drained until eoe;
//   - tag becomes 4'hA; dpram_len saturates at 1024.
//  Safety: if eoe is not seen after n_smp samples, end the event anyway.
//   Set tag 4'hA and go to DONE (no FIFO hang).
//  en deassert mid-event: the event completes; the block stays IDLE afterwards.
//  dpram_done outside WAIT: ignored.
//  hdr_empty asserting while in SMP: no effect (the header is already latched).
// STRUCTURE
//  Shared package: header/sample field offsets, tags 4'h9/4'hA, header word count 5,
//   FSM state encoding.
//  Sub-module wvb_hdr_bundle_fan_out: combinational split of hdr_data into
//   ltc, start, stop, trig_src, cnst_run (matches the existing *_bundle_fan_out style).
//  Top level: FSM, sample/phase counters, DPRAM address and write mux.
// TESTING
//  1. Header: ltc=0x123456789ABC, start=0x010, stop=0x013 (4 samples, eoe on 4th),
//     trig_src=1.
//     Expect: 13 words, w0=0x9004, w1=0x1234, w4=0x4010; dpram_len=13;
//     one hdr_rdreq pulse, one wvb_rddone pulse.
//  2. Wrap: start=0xFFE, stop=0x001.
//     Expect: n_smp=4; w0=0x9004.
//  3. Long event, start=0, stop=0x3FF (1024 samples).
//     Expect: 1024 wvb_rdreq; writes stop at a=1023; w0=0xA400; dpram_len=1024.
//  4. Two headers queued.
//     Expect: the second event is not read until dpram_done; then read.
//     dpram_done pulsed during SMP is ignored.
//  5. rst asserted mid-SMP.
//     Expect: next cycle all outputs 0, FSM IDLE.
//     Re-run scenario 1 after reset; expect an identical result.
//  6. Missing eoe with n_smp=3.
//     Expect: exactly 3 wvb_rdreq, w0=0xA003, return to WAIT.

Source files
------------

// File: rtl/wvb_reader_pkg.sv
// Shared definitions for the waveform-buffer reader: header/sample field offsets,
// DPRAM event tags, header word count and FSM state encoding.
package wvb_reader_pkg;

  localparam int unsigned HDR_LTC_LSB   = 32;
  localparam int unsigned HDR_START_LSB = 20;
  localparam int unsigned HDR_STOP_LSB  = 8;
  localparam int unsigned HDR_TRIG_LSB  = 6;
  localparam int unsigned HDR_CNST_BIT  = 5;

  localparam int unsigned SMP_EOE_BIT   = 21;
  localparam int unsigned SMP_TOT_BIT   = 20;
  localparam int unsigned SMP_DISCR_LSB = 12;
  localparam int unsigned SMP_ADC_LSB   = 0;

  localparam logic [3:0] TAG_NORMAL = 4'h9;
  localparam logic [3:0] TAG_TRUNC  = 4'hA;

  localparam int unsigned HDR_WORDS = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_HDR_WR,
    S_SMP,
    S_DONE,
    S_WAIT
  } state_t;

endpackage

// File: rtl/wvb_reader_hdr_bundle_fan_out.sv
// Combinational split of a waveform-buffer header word into its fields.
module wvb_hdr_bundle_fan_out
  import wvb_reader_pkg::*;
#(
  parameter int unsigned P_HDR_WIDTH = 80,
  parameter int unsigned P_ADR_WIDTH = 12,
  parameter int unsigned P_LTC_WIDTH = 48
) (
  input  logic [P_HDR_WIDTH-1:0] hdr_data,
  output logic [P_LTC_WIDTH-1:0] ltc,
  output logic [P_ADR_WIDTH-1:0] start,
  output logic [P_ADR_WIDTH-1:0] stop,
  output logic [1:0]             trig_src,
  output logic                   cnst_run
);

  logic hdr_rsvd_unused;

  assign ltc      = hdr_data[HDR_LTC_LSB +: P_LTC_WIDTH];
  assign start    = hdr_data[HDR_START_LSB +: P_ADR_WIDTH];
  assign stop     = hdr_data[HDR_STOP_LSB +: P_ADR_WIDTH];
  assign trig_src = hdr_data[HDR_TRIG_LSB +: 2];
  assign cnst_run = hdr_data[HDR_CNST_BIT];
  assign hdr_rsvd_unused = ^hdr_data[HDR_CNST_BIT-1:0];

endmodule

// File: rtl/wvb_reader.sv
// Waveform-buffer reader: pops one header, drains its samples and packs the event
// as 16-bit words into the readout DPRAM, then holds the DPRAM until host ack.
module wvb_reader
  import wvb_reader_pkg::*;
#(
  parameter int unsigned P_DATA_WIDTH      = 22,
  parameter int unsigned P_HDR_WIDTH       = 80,
  parameter int unsigned P_ADR_WIDTH       = 12,
  parameter int unsigned P_LTC_WIDTH       = 48,
  parameter int unsigned P_DPRAM_ADR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         hdr_empty,
  input  logic [P_HDR_WIDTH-1:0]       hdr_data,
  output logic                         hdr_rdreq,
  input  logic [P_DATA_WIDTH-1:0]      wvb_data,
  output logic                         wvb_rdreq,
  output logic                         wvb_rddone,
  output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_a,
  output logic [15:0]                  dpram_data,
  output logic                         dpram_wren,
  output logic [P_DPRAM_ADR_WIDTH:0]   dpram_len,
  output logic                         dpram_rdy,
  input  logic                         dpram_done
);

  localparam int unsigned LEN_W = P_DPRAM_ADR_WIDTH + 1;
  localparam int unsigned CNT_W = P_ADR_WIDTH + 1;
  localparam logic [LEN_W-1:0]       LEN_ONE      = LEN_W'(1);
  localparam logic [LEN_W-1:0]       HDR_LAST_ADR = LEN_W'(HDR_WORDS - 1);
  localparam logic [CNT_W-1:0]       CNT_ONE      = CNT_W'(1);
  localparam logic [P_ADR_WIDTH-1:0] ADR_ONE      = P_ADR_WIDTH'(1);

  state_t state, state_nxt;

  logic [P_HDR_WIDTH-1:0] hdr_q;
  logic [P_LTC_WIDTH-1:0] ltc;
  logic [P_ADR_WIDTH-1:0] start, stop, span;
  logic [1:0]             trig_src;
  logic                   cnst_run;
  logic [CNT_W-1:0]       n_smp, smp_cnt;
  // MSB of wr_adr flags overflow; the counter saturates there so it never wraps
  logic [LEN_W-1:0]       wr_adr;
  logic                   phase, stop_q, miss_q;
  logic [7:0]             discr_q;
  logic                   wr_req;
  logic [15:0]            wr_word;
  logic [3:0]             tag;

  logic                   smp_eoe, smp_tot;
  logic [7:0]             smp_discr;
  logic [11:0]            smp_adc;

  wvb_hdr_bundle_fan_out #(
    .P_HDR_WIDTH(P_HDR_WIDTH),
    .P_ADR_WIDTH(P_ADR_WIDTH),
    .P_LTC_WIDTH(P_LTC_WIDTH)
  ) u_hdr_fan_out (
    .hdr_data (hdr_q),
    .ltc      (ltc),
    .start    (start),
    .stop     (stop),
    .trig_src (trig_src),
    .cnst_run (cnst_run)
  );

  assign smp_eoe   = wvb_data[SMP_EOE_BIT];
  assign smp_tot   = wvb_data[SMP_TOT_BIT];
  assign smp_discr = wvb_data[SMP_DISCR_LSB +: 8];
  assign smp_adc   = wvb_data[SMP_ADC_LSB +: 12];

  // A zero span means a full buffer of 2^P_ADR_WIDTH samples
  assign span  = stop - start + ADR_ONE;
  assign n_smp = {(span == '0), span};
  assign tag   = (wr_adr[P_DPRAM_ADR_WIDTH] || miss_q) ? TAG_TRUNC : TAG_NORMAL;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (en && !hdr_empty && !dpram_rdy) state_nxt = S_HDR;
      S_HDR:    state_nxt = S_HDR_WR;
      S_HDR_WR: if (wr_adr == HDR_LAST_ADR) state_nxt = S_SMP;
      S_SMP:    if (!phase && stop_q) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_WAIT;
      S_WAIT:   if (dpram_done) state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    hdr_rdreq  = 1'b0;
    wvb_rdreq  = 1'b0;
    wvb_rddone = 1'b0;
    wr_req     = 1'b0;
    wr_word    = '0;
    dpram_a    = '0;
    dpram_data = '0;
    dpram_wren = 1'b0;
    case (state)
      S_HDR: hdr_rdreq = 1'b1;
      S_HDR_WR: begin
        wr_req = 1'b1;
        case (wr_adr[2:0])
          3'd1:    wr_word = ltc[47:32];
          3'd2:    wr_word = ltc[31:16];
          3'd3:    wr_word = ltc[15:0];
          default: wr_word = {trig_src, cnst_run, 1'b0, start};
        endcase
      end
      // Phase 1 writes word A of the sample just read; phase 0 writes the
      // previous sample's word B while requesting the next sample.
      S_SMP: begin
        if (phase) begin
          wr_req  = 1'b1;
          wr_word = {smp_tot, smp_eoe, 2'b00, smp_adc};
        end else begin
          wr_req    = (smp_cnt != '0);
          wr_word   = {8'h00, discr_q};
          wvb_rdreq = !stop_q;
        end
      end
      S_DONE: wvb_rddone = 1'b1;
      default: ;
    endcase
    if (state == S_DONE) begin
      dpram_wren = 1'b1;
      dpram_a    = '0;
      dpram_data = {tag, n_smp[P_ADR_WIDTH-1:0]};
    end else if (wr_req) begin
      dpram_wren = !wr_adr[P_DPRAM_ADR_WIDTH];
      dpram_a    = wr_adr[P_DPRAM_ADR_WIDTH-1:0];
      dpram_data = wr_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hdr_q     <= '0;
      wr_adr    <= '0;
      smp_cnt   <= '0;
      phase     <= 1'b0;
      stop_q    <= 1'b0;
      miss_q    <= 1'b0;
      discr_q   <= '0;
      dpram_len <= '0;
      dpram_rdy <= 1'b0;
    end else begin
      if (wr_req && !wr_adr[P_DPRAM_ADR_WIDTH]) wr_adr <= wr_adr + LEN_ONE;
      case (state)
        S_HDR: begin
          hdr_q   <= hdr_data;
          wr_adr  <= LEN_ONE;
          smp_cnt <= '0;
          phase   <= 1'b0;
          stop_q  <= 1'b0;
          miss_q  <= 1'b0;
        end
        S_SMP: begin
          phase <= !phase;
          if (phase) begin
            smp_cnt <= smp_cnt + CNT_ONE;
            discr_q <= smp_discr;
            if (smp_eoe || (smp_cnt + CNT_ONE == n_smp)) begin
              stop_q <= 1'b1;
              miss_q <= !smp_eoe;
            end
          end
        end
        S_DONE: begin
          dpram_len <= wr_adr;
          dpram_rdy <= 1'b1;
        end
        S_WAIT: if (dpram_done) dpram_rdy <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wvb_reader.sv
// Scoreboard bench for wvb_reader: stimulus queues expected event images,
// a monitor rebuilds each event from DPRAM writes and compares on completion.
module tb_wvb_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        hdr_empty = 1'b1;
  logic [79:0] hdr_data = '0;
  logic        hdr_rdreq;
  logic [21:0] wvb_data = '0;
  logic        wvb_rdreq;
  logic        wvb_rddone;
  logic [9:0]  dpram_a;
  logic [15:0] dpram_data;
  logic        dpram_wren;
  logic [10:0] dpram_len;
  logic        dpram_rdy;
  logic        dpram_done = 1'b0;

  wvb_reader #(
    .P_DATA_WIDTH(22), .P_HDR_WIDTH(80), .P_ADR_WIDTH(12),
    .P_LTC_WIDTH(48), .P_DPRAM_ADR_WIDTH(10)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hdr_empty(hdr_empty), .hdr_data(hdr_data),
    .hdr_rdreq(hdr_rdreq), .wvb_data(wvb_data), .wvb_rdreq(wvb_rdreq),
    .wvb_rddone(wvb_rddone), .dpram_a(dpram_a), .dpram_data(dpram_data),
    .dpram_wren(dpram_wren), .dpram_len(dpram_len), .dpram_rdy(dpram_rdy),
    .dpram_done(dpram_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w0, w1, w2, w3, w4, w5, w6;
    int len, n_rd, max_adr;
  } exp_t;

  exp_t        sb[$];
  logic [79:0] hdr_fifo[$];
  logic [21:0] smp_q[$];
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Header FIFO and sample buffer models: pop on the cycle after a request is seen
  logic hpop = 1'b0, spop = 1'b0;
  always @(negedge clk) begin
    hpop = hdr_rdreq;
    spop = wvb_rdreq;
  end
  always @(posedge clk) begin
    #1;
    if (hpop && hdr_fifo.size() > 0) void'(hdr_fifo.pop_front());
    if (spop && smp_q.size() > 0) wvb_data = smp_q.pop_front();
    hdr_empty = (hdr_fifo.size() == 0);
    hdr_data  = (hdr_fifo.size() > 0) ? hdr_fifo[0] : '0;
  end

  // Monitor
  logic [15:0] mem [0:1023];
  int m_rd = 0, m_hdr = 0, m_done = 0, m_max = -1;
  logic cmp_pending = 1'b0;

  task automatic clear_event();
    for (int i = 0; i < 1024; i++) mem[i] = 16'hDEAD;
    m_rd = 0; m_hdr = 0; m_done = 0; m_max = -1;
  endtask

  initial clear_event();

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      clear_event();
      cmp_pending = 1'b0;
    end else begin
      if (dpram_wren) begin
        mem[dpram_a] = dpram_data;
        if (int'(dpram_a) > m_max) m_max = int'(dpram_a);
      end
      if (wvb_rdreq) m_rd++;
      if (hdr_rdreq) m_hdr++;
      if (wvb_rddone) m_done++;
      if (cmp_pending) begin
        cmp_pending = 1'b0;
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_unexpected: got an event, expected none queued");
        end else begin
          e = sb.pop_front();
          check("w0", mem[0], e.w0);
          check("w1", mem[1], e.w1);
          check("w2", mem[2], e.w2);
          check("w3", mem[3], e.w3);
          check("w4", mem[4], e.w4);
          check("w5", mem[5], e.w5);
          check("w6", mem[6], e.w6);
          check("dpram_len", dpram_len, e.len);
          check("dpram_rdy", dpram_rdy, 1);
          check("n_wvb_rdreq", m_rd, e.n_rd);
          check("max_adr", m_max, e.max_adr);
          check("n_hdr_rdreq", m_hdr, 1);
          check("n_wvb_rddone", m_done, 1);
        end
        clear_event();
      end else if (wvb_rddone) begin
        cmp_pending = 1'b1;
      end
    end
  end

  // Stimulus helpers
  function automatic logic [79:0] mk_hdr(input logic [47:0] ltc, input logic [11:0] start,
                                         input logic [11:0] stop, input logic [1:0] trig,
                                         input logic cnst);
    return {ltc, start, stop, trig, cnst, 5'b0};
  endfunction

  // Sample i: eoe optional on the last, tot=i[0], discr=i+1, adc=0x100+i
  task automatic push_samples(input int n, input bit eoe_last);
    for (int i = 0; i < n; i++) begin
      logic eoe = eoe_last && (i == n - 1);
      smp_q.push_back({eoe, 1'(i), 8'(i + 1), 12'(12'h100 + i)});
    end
  endtask

  task automatic push_exp(input logic [15:0] w0, w1, w2, w3, w4,
                          input int len, input int n_rd, input int max_adr);
    exp_t e;
    e.w0 = w0; e.w1 = w1; e.w2 = w2; e.w3 = w3; e.w4 = w4;
    e.w5 = 16'h0100; e.w6 = 16'h0001;
    e.len = len; e.n_rd = n_rd; e.max_adr = max_adr;
    sb.push_back(e);
  endtask

  task automatic wait_rdy(input string name);
    int n = 0;
    while (dpram_rdy !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (dpram_rdy !== 1'b1) begin
      n_total++;
      $display("FAIL %s: dpram_rdy=%b after %0d cycles, expected 1", name, dpram_rdy, n);
    end
  endtask

  task automatic ack();
    @(negedge clk) dpram_done = 1'b1;
    @(negedge clk) dpram_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_hdr_rdreq"}, hdr_rdreq, 0);
    check({tag, "_wvb_rdreq"}, wvb_rdreq, 0);
    check({tag, "_wvb_rddone"}, wvb_rddone, 0);
    check({tag, "_dpram_a"}, dpram_a, 0);
    check({tag, "_dpram_data"}, dpram_data, 0);
    check({tag, "_dpram_wren"}, dpram_wren, 0);
    check({tag, "_dpram_len"}, dpram_len, 0);
    check({tag, "_dpram_rdy"}, dpram_rdy, 0);
  endtask

  task automatic run_case1();
    push_samples(4, 1'b1);
    push_exp(16'h9004, 16'h1234, 16'h5678, 16'h9ABC, 16'h4010, 13, 4, 12);
    hdr_fifo.push_back(mk_hdr(48'h123456789ABC, 12'h010, 12'h013, 2'd1, 1'b0));
    wait_rdy("case1_rdy");
    ack();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, %0d/%0d done", n_pass, n_total);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    en  = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic event
    run_case1();

    // 2: start/stop wrap
    push_samples(4, 1'b1);
    push_exp(16'h9004, 16'h0000, 16'h0000, 16'h0000, 16'h2FFE, 13, 4, 12);
    hdr_fifo.push_back(mk_hdr(48'h0, 12'hFFE, 12'h001, 2'd0, 1'b1));
    wait_rdy("case2_rdy");
    ack();

    // 3: long event overflowing the DPRAM
    push_samples(1024, 1'b1);
    push_exp(16'hA400, 16'hAAAA, 16'h5555, 16'h0001, 16'h8000, 1024, 1024, 1023);
    hdr_fifo.push_back(mk_hdr(48'hAAAA55550001, 12'h000, 12'h3FF, 2'd2, 1'b0));
    wait_rdy("case3_rdy");
    ack();

    // 4: two headers queued, stray dpram_done during SMP
    push_samples(4, 1'b1);
    push_samples(4, 1'b1);
    push_exp(16'h9004, 16'h1234, 16'h5678, 16'h9ABC, 16'h4010, 13, 4, 12);
    push_exp(16'h9004, 16'h0000, 16'h0000, 16'h0000, 16'h2FFE, 13, 4, 12);
    hdr_fifo.push_back(mk_hdr(48'h123456789ABC, 12'h010, 12'h013, 2'd1, 1'b0));
    hdr_fifo.push_back(mk_hdr(48'h0, 12'hFFE, 12'h001, 2'd0, 1'b1));
    begin
      int n = 0;
      while (wvb_rdreq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      dpram_done = 1'b1;
      @(negedge clk) dpram_done = 1'b0;
    end
    wait_rdy("case4a_rdy");
    repeat (20) @(negedge clk);
    check("holdoff_fifo", hdr_fifo.size(), 1);
    check("holdoff_rdy", dpram_rdy, 1);
    ack();
    wait_rdy("case4b_rdy");
    ack();

    // 5: reset in the middle of the sample loop, then repeat case 1
    push_samples(4, 1'b1);
    hdr_fifo.push_back(mk_hdr(48'h123456789ABC, 12'h010, 12'h013, 2'd1, 1'b0));
    begin
      int n = 0, seen = 0;
      while (seen < 2 && n < 100) begin
        @(negedge clk);
        n++;
        if (wvb_rdreq === 1'b1) seen++;
      end
    end
    rst = 1'b1;
    @(negedge clk);
    check_idle("mid_rst");
    rst = 1'b0;
    smp_q.delete();
    repeat (2) @(negedge clk);
    run_case1();

    // 6: eoe never arrives, n_smp=3; extra samples available must not be read
    push_samples(5, 1'b0);
    push_exp(16'hA003, 16'h0000, 16'h1111, 16'h2222, 16'hE020, 11, 3, 10);
    hdr_fifo.push_back(mk_hdr(48'h000011112222, 12'h020, 12'h022, 2'd3, 1'b1));
    wait_rdy("case6_rdy");
    ack();
    smp_q.delete();

    repeat (5) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
